// File: rtl/data_memory_responder.sv
// data_memory_responder
//   Data-memory slave for the 8-bit single-cycle CPU. Models a multi-cycle
//   byte memory of 2**ADDR_WIDTH entries. It stalls the CPU through
//   BUSYWAIT for LATENCY+1 cycles, performs the latched access, and then
//   gives one acknowledge cycle with BUSYWAIT low.
//
// Ports
//   CLK        clock, all state changes on posedge
//   RESET      asynchronous active-low reset (memory array is not cleared)
//   READ       read request, held by the CPU until BUSYWAIT falls
//   WRITE      write request, held by the CPU until BUSYWAIT falls
//              (wins over READ when both are high)
//   ADDRESS    byte address, latched when the request is accepted
//   WRITEDATA  store data, latched when the request is accepted
//   READDATA   load data; changes only when a read completes or on reset
//   BUSYWAIT   stall, high while a request is outstanding and not yet acked
module data_memory_responder #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 8,
   parameter int LATENCY    = 5
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic                  READ,
   input  logic                  WRITE,
   input  logic [ADDR_WIDTH-1:0] ADDRESS,
   input  logic [DATA_WIDTH-1:0] WRITEDATA,
   output logic [DATA_WIDTH-1:0] READDATA,
   output logic                  BUSYWAIT
);

   localparam int         DEPTH    = 2**ADDR_WIDTH;
   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      ACK
   } state_t;

   state_t                  state;
   state_t                  next_state;
   logic [3:0]              cnt;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   data_q;
   logic                    wr_q;
   logic                    start;
   logic                    done;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   // State register
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next state, stall output and datapath strobes.
   // BUSYWAIT is gated by RESET so it falls the instant reset is asserted,
   // even in the middle of an access.
   always_comb begin
      next_state = state;
      BUSYWAIT   = 1'b0;
      start      = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (READ || WRITE) begin
               BUSYWAIT   = RESET;
               start      = 1'b1;
               next_state = ACCESS;
            end
         end
         ACCESS: begin
            BUSYWAIT = RESET;
            if (cnt == '0) begin
               done       = 1'b1;
               next_state = ACK;
            end
         end
         ACK: begin
            next_state = IDLE;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Request latch, latency counter and load data
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         cnt      <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         wr_q     <= 1'b0;
         READDATA <= '0;
      end else begin
         if (start) begin
            addr_q <= ADDRESS;
            data_q <= WRITEDATA;
            wr_q   <= WRITE;
            cnt    <= CNT_INIT;
         end else if (state == ACCESS && cnt != '0) begin
            cnt <= cnt - 4'd1;
         end
         if (done && !wr_q) begin
            READDATA <= mem[addr_q];
         end
      end
   end

   // Storage array; no reset so contents survive RESET. A reset during
   // ACCESS forces IDLE, so done is never set and the write is dropped.
   always_ff @(posedge CLK) begin
      if (done && wr_q) begin
         mem[addr_q] <= data_q;
      end
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb_data_memory_responder
//   Directed bench for data_memory_responder. One instance uses the
//   default LATENCY of 5, a second uses LATENCY=1 for the back-to-back
//   store/load case. Inputs change on the falling edge, outputs are
//   sampled 1 time unit after the falling edge.
module tb_data_memory_responder;

   logic       CLK;
   logic       RESET;

   logic       READ;
   logic       WRITE;
   logic [7:0] ADDRESS;
   logic [7:0] WRITEDATA;
   logic [7:0] READDATA;
   logic       BUSYWAIT;

   logic       READ1;
   logic       WRITE1;
   logic [7:0] ADDRESS1;
   logic [7:0] WRITEDATA1;
   logic [7:0] READDATA1;
   logic       BUSYWAIT1;

   int checks = 0;
   int errors = 0;

   data_memory_responder #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (8),
      .LATENCY    (5)
   ) dut (
      .CLK       (CLK),
      .RESET     (RESET),
      .READ      (READ),
      .WRITE     (WRITE),
      .ADDRESS   (ADDRESS),
      .WRITEDATA (WRITEDATA),
      .READDATA  (READDATA),
      .BUSYWAIT  (BUSYWAIT)
   );

   data_memory_responder #(
      .ADDR_WIDTH (8),
      .DATA_WIDTH (8),
      .LATENCY    (1)
   ) dut_l1 (
      .CLK       (CLK),
      .RESET     (RESET),
      .READ      (READ1),
      .WRITE     (WRITE1),
      .ADDRESS   (ADDRESS1),
      .WRITEDATA (WRITEDATA1),
      .READDATA  (READDATA1),
      .BUSYWAIT  (BUSYWAIT1)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Presents a request on the LATENCY=5 instance and counts the busy
   // cycles (bounded). Returns in the first non-busy cycle (ACK) with the
   // request lines already dropped.
   task automatic run_access(input logic rd, input logic wr, input logic [7:0] a,
                             input logic [7:0] d, output int busy);
      READ      = rd;
      WRITE     = wr;
      ADDRESS   = a;
      WRITEDATA = d;
      #1;
      busy = 0;
      while (BUSYWAIT === 1'b1 && busy < 40) begin
         busy++;
         @(negedge CLK);
         #1;
      end
      READ  = 1'b0;
      WRITE = 1'b0;
   endtask

   int n;

   initial begin
      RESET      = 1'b0;
      READ       = 1'b1;
      WRITE      = 1'b0;
      ADDRESS    = 8'h00;
      WRITEDATA  = 8'h00;
      READ1      = 1'b0;
      WRITE1     = 1'b0;
      ADDRESS1   = 8'h00;
      WRITEDATA1 = 8'h00;

      // Reset held for two cycles, with a request pending
      repeat (2) @(negedge CLK);
      #1;
      check("rst_busywait_forced_low", 32'(BUSYWAIT), 32'd0);
      check("rst_readdata", 32'(READDATA), 32'h00);
      READ  = 1'b0;
      RESET = 1'b1;
      @(negedge CLK);

      // Store 0x5A to 0x10
      run_access(1'b0, 1'b1, 8'h10, 8'h5A, n);
      check("store_busy_cycles", 32'(n), 32'd6);
      check("store_ack_readdata", 32'(READDATA), 32'h00);
      @(negedge CLK);
      #1;
      check("store_idle_busywait", 32'(BUSYWAIT), 32'd0);

      // Store 0x99 to 0x20 so the mid-access test can tell addresses apart
      run_access(1'b0, 1'b1, 8'h20, 8'h99, n);
      check("store20_busy_cycles", 32'(n), 32'd6);
      @(negedge CLK);

      // Load 0x10
      run_access(1'b1, 1'b0, 8'h10, 8'h00, n);
      check("load_busy_cycles", 32'(n), 32'd6);
      check("load_ack_readdata", 32'(READDATA), 32'h5A);
      @(negedge CLK);
      #1;
      check("load_idle_busywait", 32'(BUSYWAIT), 32'd0);
      check("load_idle_readdata", 32'(READDATA), 32'h5A);
      @(negedge CLK);
      #1;
      check("load_idle2_readdata", 32'(READDATA), 32'h5A);

      // Load 0x10, switch ADDRESS to 0x20 and drop READ in the 3rd busy cycle
      READ      = 1'b1;
      ADDRESS   = 8'h10;
      #1;
      n = 0;
      while (BUSYWAIT === 1'b1 && n < 40) begin
         if (n == 2) begin
            ADDRESS = 8'h20;
            READ    = 1'b0;
         end
         n++;
         @(negedge CLK);
         #1;
      end
      check("midchg_busy_cycles", 32'(n), 32'd6);
      check("midchg_readdata", 32'(READDATA), 32'h5A);
      @(negedge CLK);

      // READ and WRITE together: treated as a write
      run_access(1'b1, 1'b1, 8'h33, 8'hC3, n);
      check("both_busy_cycles", 32'(n), 32'd6);
      check("both_readdata_unchanged", 32'(READDATA), 32'h5A);
      @(negedge CLK);
      run_access(1'b1, 1'b0, 8'h33, 8'h00, n);
      check("both_readback_busy", 32'(n), 32'd6);
      check("both_readback_data", 32'(READDATA), 32'hC3);
      @(negedge CLK);

      // Reset in the middle of a write: prior contents of 0x44 survive
      run_access(1'b0, 1'b1, 8'h44, 8'h11, n);
      check("pre44_busy_cycles", 32'(n), 32'd6);
      @(negedge CLK);
      WRITE     = 1'b1;
      ADDRESS   = 8'h44;
      WRITEDATA = 8'h77;
      repeat (3) @(negedge CLK);
      #1;
      check("abort_busy_before_reset", 32'(BUSYWAIT), 32'd1);
      RESET = 1'b0;
      WRITE = 1'b0;
      #1;
      check("abort_busywait_async", 32'(BUSYWAIT), 32'd0);
      check("abort_readdata_cleared", 32'(READDATA), 32'h00);
      @(negedge CLK);
      RESET = 1'b1;
      #1;
      check("abort_idle_busywait", 32'(BUSYWAIT), 32'd0);
      @(negedge CLK);
      run_access(1'b1, 1'b0, 8'h44, 8'h00, n);
      check("abort_readback_busy", 32'(n), 32'd6);
      check("abort_readback_data", 32'(READDATA), 32'h11);
      @(negedge CLK);

      // LATENCY=1: store then load held through ACK
      WRITE1     = 1'b1;
      ADDRESS1   = 8'h05;
      WRITEDATA1 = 8'h3C;
      #1;
      check("l1_store_busy_c0", 32'(BUSYWAIT1), 32'd1);
      @(negedge CLK);
      #1;
      check("l1_store_busy_c1", 32'(BUSYWAIT1), 32'd1);
      @(negedge CLK);
      #1;
      check("l1_store_ack_busy", 32'(BUSYWAIT1), 32'd0);
      check("l1_store_ack_readdata", 32'(READDATA1), 32'h00);
      WRITE1 = 1'b0;
      READ1  = 1'b1;
      @(negedge CLK);
      #1;
      check("l1_load_idle_busy", 32'(BUSYWAIT1), 32'd1);
      @(negedge CLK);
      #1;
      check("l1_load_access_busy", 32'(BUSYWAIT1), 32'd1);
      @(negedge CLK);
      #1;
      check("l1_load_ack_busy", 32'(BUSYWAIT1), 32'd0);
      check("l1_load_ack_readdata", 32'(READDATA1), 32'h3C);
      READ1 = 1'b0;
      @(negedge CLK);
      #1;
      check("l1_idle_busy", 32'(BUSYWAIT1), 32'd0);
      check("l1_idle_readdata", 32'(READDATA1), 32'h3C);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
